// File: rtl/note_recorder.sv
// ============================================================================
// Module   : note_recorder
// Purpose  : Run-length encodes held chords {keys,octave,duration} into records
//            and streams them to song memory over a valid/ready handshake.
// Config   : REC_SKIP_LEADING_REST_EN - suppress the leading rest of a take
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_recorder #(
    parameter int TICK_DIV   = 10_000_000,
    parameter int DUR_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_rec_en,
    input  logic [7:0]          i_keys,
    input  logic [1:0]          i_octave,
    input  logic                i_mem_full,
    input  logic                i_wr_ready,
    output logic                o_wr_valid,
    output logic [10+DUR_W-1:0] o_wr_data,
    output logic                o_busy,
    output logic                o_overflow,
    output logic [7:0]          o_rec_count
);

    localparam int C_REC_W = 10 + DUR_W;
    localparam int C_PS_W  = $clog2(TICK_DIV);
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_rec_en_d;
    logic                  r_marker_done;
    logic [9:0]            r_run_note;
    logic [DUR_W-1:0]      r_dur;
    logic [C_PS_W-1:0]     r_prescaler;
    logic                  r_overflow;
    logic [7:0]            r_rec_count;

    logic [C_REC_W-1:0]    r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic                  r_wr_valid;
    logic [C_REC_W-1:0]    r_wr_data;

    logic [9:0]            w_cur_note;
    logic                  w_change;
    logic                  w_tick;
    logic                  w_dur_max;
    logic                  w_emit;
    logic [C_REC_W-1:0]    w_emit_data;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [C_CNT_W-1:0]    w_after_pop;
    logic [C_CNT_W-1:0]    w_count_next;
    logic [C_PTR_W-1:0]    w_rd_ptr_next;
    logic [C_REC_W-1:0]    w_head_next;

    assign w_cur_note = {i_keys, i_octave};
    assign w_change   = (w_cur_note != r_run_note);
    assign w_tick     = (r_prescaler == C_PS_W'(TICK_DIV - 1));
    assign w_dur_max  = (r_dur == {DUR_W{1'b1}});

    // Record emission follows the CAPTURE priority order; the marker is all zeros.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_data = {r_run_note, r_dur};
        case (r_state)
            S_CAPTURE: begin
                if (!i_rec_en || i_mem_full) begin
                    w_emit = 1'b1;
                end else if (w_change) begin
                    w_emit = 1'b1;
                end else if (w_tick && w_dur_max) begin
                    w_emit = 1'b1;
                end
            end
            S_FLUSH: begin
                if (!r_marker_done) begin
                    w_emit      = 1'b1;
                    w_emit_data = '0;
                end
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full        = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign w_pop         = r_wr_valid && i_wr_ready;
    assign w_push        = w_emit && (!w_full || w_pop);
    assign w_drop        = w_emit && !w_push;
    assign w_after_pop   = r_count - C_CNT_W'(w_pop);
    assign w_count_next  = w_after_pop + C_CNT_W'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + C_PTR_W'(w_pop);
    assign w_head_next   = (w_after_pop == '0) ? w_emit_data : r_mem[w_rd_ptr_next];

    always_ff @(posedge i_sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_emit_data;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_wr_valid <= (w_count_next != '0);
            r_wr_data  <= (w_count_next != '0) ? w_head_next : '0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rec_en_d    <= 1'b0;
            r_marker_done <= 1'b0;
            r_run_note    <= '0;
            r_dur         <= '0;
            r_prescaler   <= '0;
            r_overflow    <= 1'b0;
            r_rec_count   <= '0;
        end else begin
            r_rec_en_d <= i_rec_en;
            if (w_push && (r_rec_count != 8'hFF)) begin
                r_rec_count <= r_rec_count + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rec_en && !r_rec_en_d) begin
                        r_overflow  <= 1'b0;
                        r_rec_count <= '0;
                        r_state     <= S_ARMED;
                    end
                end
                S_ARMED: begin
`ifdef REC_SKIP_LEADING_REST_EN
                    if (!i_rec_en) begin
                        r_state <= S_IDLE;
                    end else if (i_keys != 8'h00) begin
                        r_run_note  <= w_cur_note;
                        r_dur       <= DUR_W'(1);
                        r_prescaler <= '0;
                        r_state     <= S_CAPTURE;
                    end
`else
                    r_run_note  <= w_cur_note;
                    r_dur       <= DUR_W'(1);
                    r_prescaler <= '0;
                    r_state     <= S_CAPTURE;
`endif
                end
                S_CAPTURE: begin
                    if (!i_rec_en || i_mem_full) begin
                        r_marker_done <= 1'b0;
                        r_state       <= S_FLUSH;
                    end else if (w_change) begin
                        // A tick coinciding with a change is discarded.
                        r_run_note  <= w_cur_note;
                        r_dur       <= DUR_W'(1);
                        r_prescaler <= '0;
                    end else if (w_tick) begin
                        r_prescaler <= '0;
                        r_dur       <= w_dur_max ? DUR_W'(1) : r_dur + DUR_W'(1);
                    end else begin
                        r_prescaler <= r_prescaler + C_PS_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (!r_marker_done) begin
                        r_marker_done <= 1'b1;
                    end else if (r_count == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wr_valid  = r_wr_valid;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_overflow  = r_overflow;
    assign o_rec_count = r_rec_count;

endmodule

`default_nettype wire

// File: tb/tb_note_recorder.sv
// ============================================================================
// Module   : tb_note_recorder
// Purpose  : Directed self-checking bench for note_recorder (TICK_DIV=4).
//            Expectations follow REC_SKIP_LEADING_REST_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_recorder;

    logic        clk;
    logic        rst;
    logic        rec_en;
    logic [7:0]  keys;
    logic [1:0]  octave;
    logic        mem_full;
    logic        wr_ready;
    logic        wr_valid;
    logic [17:0] wr_data;
    logic        busy;
    logic        overflow;
    logic [7:0]  rec_count;

    int tests_run;
    int tests_failed;

    logic [17:0] q [$];

    note_recorder #(
        .TICK_DIV   (4),
        .DUR_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .i_sys_clk   (clk),
        .i_rst       (rst),
        .i_rec_en    (rec_en),
        .i_keys      (keys),
        .i_octave    (octave),
        .i_mem_full  (mem_full),
        .i_wr_ready  (wr_ready),
        .o_wr_valid  (wr_valid),
        .o_wr_data   (wr_data),
        .o_busy      (busy),
        .o_overflow  (overflow),
        .o_rec_count (rec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records leaving the DUT, captured mid-cycle before the transferring edge.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            q.push_back(wr_data);
        end
    end

    function automatic logic [17:0] mk(input logic [7:0] k, input logic [1:0] o, input logic [7:0] d);
        return {k, o, d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle_timeout busy=%b expected 0", name, busy);
        end
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        tests_run++;
        if ({wr_valid, busy, overflow, rec_count, wr_data} !== 29'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%b b=%b ov=%b cnt=%0d d=%h expected all 0",
                     wr_valid, busy, overflow, rec_count, wr_data);
        end
        rst = 1'b0;
        step(2);
        tests_run++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release busy=%b valid=%b expected 0 0", busy, wr_valid);
        end
    endtask

    task automatic test_basic();
        logic [17:0] exp [$];
        logic [17:0] got;
        q.delete();
        wr_ready = 1'b1;
        rec_en = 1'b1; keys = 8'h01; octave = 2'd1;
        step(10);
        tests_run++;
        if (wr_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_pre_emit valid=%b busy=%b expected 0 1", wr_valid, busy);
        end
        keys = 8'h00;
        step(1);
        tests_run++;
        if (wr_valid !== 1'b1 || wr_data !== mk(8'h01, 2'd1, 8'd3)) begin
            tests_failed++;
            $display("FAIL basic_latency valid=%b data=%h expected 1 %h",
                     wr_valid, wr_data, mk(8'h01, 2'd1, 8'd3));
        end
        step(4);
        rec_en = 1'b0;
        wait_idle("basic");
        exp = '{mk(8'h01, 2'd1, 8'd3), mk(8'h00, 2'd1, 8'd2), 18'd0};
        tests_run++;
        if (q.size() != exp.size()) begin
            tests_failed++;
            $display("FAIL basic_count records=%0d expected %0d", q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < q.size()) ? q[i] : 18'bx;
            tests_run++;
            if (got !== exp[i]) begin
                tests_failed++;
                $display("FAIL basic_rec%0d got %h expected %h", i, got, exp[i]);
            end
        end
        tests_run++;
        if (rec_count !== 8'd3) begin
            tests_failed++;
            $display("FAIL basic_rec_count got %0d expected 3", rec_count);
        end
    endtask

    task automatic test_saturate();
        logic [17:0] exp [$];
        logic [17:0] got;
        q.delete();
        wr_ready = 1'b1;
        rec_en = 1'b1; keys = 8'h80; octave = 2'd2;
        step(1021);
        tests_run++;
        if (wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_early valid=%b expected 0", wr_valid);
        end
        step(1);
        tests_run++;
        if (wr_valid !== 1'b1 || wr_data !== mk(8'h80, 2'd2, 8'd255)) begin
            tests_failed++;
            $display("FAIL sat_record valid=%b data=%h expected 1 %h",
                     wr_valid, wr_data, mk(8'h80, 2'd2, 8'd255));
        end
        step(7);
        keys = 8'h40;
        step(1);
        rec_en = 1'b0;
        wait_idle("sat");
        exp = '{mk(8'h80, 2'd2, 8'd255), mk(8'h80, 2'd2, 8'd2), mk(8'h40, 2'd2, 8'd1), 18'd0};
        tests_run++;
        if (q.size() != exp.size()) begin
            tests_failed++;
            $display("FAIL sat_count records=%0d expected %0d", q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < q.size()) ? q[i] : 18'bx;
            tests_run++;
            if (got !== exp[i]) begin
                tests_failed++;
                $display("FAIL sat_rec%0d got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [17:0] exp [$];
        logic [17:0] got;
        logic [7:0]  seq [6];
        q.delete();
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        wr_ready = 1'b0;
        rec_en = 1'b1; keys = 8'h01; octave = 2'd0;
        step(2);
        for (int i = 0; i < 6; i++) begin
            keys = seq[i];
            step(1);
        end
        rec_en = 1'b0;
        step(2);
        tests_run++;
        if (overflow !== 1'b1 || rec_count !== 8'd4) begin
            tests_failed++;
            $display("FAIL ovf_flags overflow=%b rec_count=%0d expected 1 4", overflow, rec_count);
        end
        tests_run++;
        if (wr_valid !== 1'b1 || busy !== 1'b1 || wr_data !== mk(8'h01, 2'd0, 8'd1)) begin
            tests_failed++;
            $display("FAIL ovf_stall_head valid=%b busy=%b data=%h expected 1 1 %h",
                     wr_valid, busy, wr_data, mk(8'h01, 2'd0, 8'd1));
        end
        step(3);
        tests_run++;
        if (wr_valid !== 1'b1 || wr_data !== mk(8'h01, 2'd0, 8'd1)) begin
            tests_failed++;
            $display("FAIL ovf_stable valid=%b data=%h expected 1 %h",
                     wr_valid, wr_data, mk(8'h01, 2'd0, 8'd1));
        end
        wr_ready = 1'b1;
        wait_idle("ovf");
        exp = '{mk(8'h01, 2'd0, 8'd1), mk(8'h02, 2'd0, 8'd1),
                mk(8'h04, 2'd0, 8'd1), mk(8'h08, 2'd0, 8'd1)};
        tests_run++;
        if (q.size() != exp.size()) begin
            tests_failed++;
            $display("FAIL ovf_count records=%0d expected %0d", q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < q.size()) ? q[i] : 18'bx;
            tests_run++;
            if (got !== exp[i]) begin
                tests_failed++;
                $display("FAIL ovf_rec%0d got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_mem_full();
        q.delete();
        wr_ready = 1'b1;
        rec_en = 1'b1; keys = 8'h04; octave = 2'd3;
        step(6);
        mem_full = 1'b1;
        step(1);
        mem_full = 1'b0;
        rec_en = 1'b0;
        step(1);
        rec_en = 1'b1;
        step(1);
        rec_en = 1'b0;
        step(3);
        tests_run++;
        if (busy !== 1'b0 || rec_count !== 8'd2 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_idle busy=%b rec_count=%0d overflow=%b expected 0 2 0",
                     busy, rec_count, overflow);
        end
        tests_run++;
        if (q.size() != 2) begin
            tests_failed++;
            $display("FAIL full_count records=%0d expected 2", q.size());
        end else begin
            tests_run++;
            if (q[0] !== mk(8'h04, 2'd3, 8'd2) || q[1] !== 18'd0) begin
                tests_failed++;
                $display("FAIL full_recs got %h %h expected %h 00000",
                         q[0], q[1], mk(8'h04, 2'd3, 8'd2));
            end
        end
    endtask

    task automatic test_reset_mid_take();
        q.delete();
        wr_ready = 1'b0;
        rec_en = 1'b1; keys = 8'h01; octave = 2'd0;
        step(2);
        keys = 8'h02;
        step(1);
        keys = 8'h04;
        step(1);
        tests_run++;
        if (rec_count !== 8'd2 || wr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre rec_count=%0d valid=%b expected 2 1", rec_count, wr_valid);
        end
        rst = 1'b1;
        rec_en = 1'b0;
        step(1);
        tests_run++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || rec_count !== 8'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_state valid=%b busy=%b rec_count=%0d overflow=%b expected 0 0 0 0",
                     wr_valid, busy, rec_count, overflow);
        end
        rst = 1'b0;
        wr_ready = 1'b1;
        step(6);
        tests_run++;
        if (q.size() != 0 || wr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_marker records=%0d valid=%b expected 0 0", q.size(), wr_valid);
        end
    endtask

    task automatic test_leading_rest();
        logic [17:0] exp [$];
        logic [17:0] got;
        q.delete();
        wr_ready = 1'b1;
        rec_en = 1'b1; keys = 8'h00; octave = 2'd1;
        step(10);
        keys = 8'h04;
        step(1);
        rec_en = 1'b0;
        wait_idle("lead");
`ifdef REC_SKIP_LEADING_REST_EN
        exp = '{mk(8'h04, 2'd1, 8'd1), 18'd0};
`else
        exp = '{mk(8'h00, 2'd1, 8'd3), mk(8'h04, 2'd1, 8'd1), 18'd0};
`endif
        tests_run++;
        if (q.size() != exp.size()) begin
            tests_failed++;
            $display("FAIL lead_count records=%0d expected %0d", q.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < q.size()) ? q[i] : 18'bx;
            tests_run++;
            if (got !== exp[i]) begin
                tests_failed++;
                $display("FAIL lead_rec%0d got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        rec_en   = 1'b0;
        keys     = 8'h00;
        octave   = 2'd0;
        mem_full = 1'b0;
        wr_ready = 1'b1;
        step(1);
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_mem_full();
        test_reset_mid_take();
        test_leading_rest();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
